// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-bank responder. Oversampled in the clk domain; nothing
// is clocked by spi_clk. Frames are 16 bits, MSB first: {W, addr[6:0], data[7:0]}.
// Writes commit at frame end; read data is shifted out on the data byte.
module spi_reg_slave #(
    parameter int         NREG        = 4,
    parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              dout,
    input  logic [7:0]        status,
    output logic [NREG*8-1:0] regs,
    output logic              wr_strobe,
    output logic [6:0]        wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_err
);

    localparam logic [7:0] NREG_W = 8'(NREG);

    // Synchronisers: [0] first stage, [1] synced value, [2] edge-detect history
    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_mosi_sync;

    logic [4:0]  r_bit_cnt;
    logic [15:0] r_rx;
    logic [7:0]  r_tx;
    logic [7:0]  r_regs [NREG];
    logic        r_wr_strobe;
    logic [6:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_frame_err;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic        w_cs_active;
    logic [15:0] w_rx_next;
    logic [6:0]  w_hdr_addr;
    logic        w_hdr_write;
    logic [7:0]  w_rd_data;
    logic        w_load_tx;
    logic        w_shift_tx;
    logic        w_commit;
    logic        w_bad_len;

    // Bring the SPI pins into the clk domain; idle values are cs high, clk/mosi low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_active = ~r_cs_sync[1];

    // Header decode, read-data mux and frame-end classification
    always_comb begin
        w_rx_next   = {r_rx[14:0], r_mosi_sync[1]};
        w_hdr_addr  = w_rx_next[6:0];
        w_hdr_write = w_rx_next[7];
        w_rd_data   = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            w_rd_data = w_rd_data | ((w_hdr_addr == 7'(i)) ? r_regs[i] : 8'h00);
        end
        if (w_hdr_addr == STATUS_ADDR) begin
            w_rd_data = status;
        end else begin
            w_rd_data = w_rd_data;
        end
        w_load_tx  = w_sclk_rise & w_cs_active & (r_bit_cnt == 5'd7);
        w_shift_tx = w_sclk_fall & w_cs_active &
                     (r_bit_cnt >= 5'd9) & (r_bit_cnt <= 5'd15);
        w_commit   = w_cs_rise & (r_bit_cnt == 5'd16) & r_rx[15] &
                     ({1'b0, r_rx[14:8]} < NREG_W);
        w_bad_len  = w_cs_rise & (r_bit_cnt != 5'd0) & (r_bit_cnt != 5'd16);
    end

    // Receive shifter and saturating bit counter; a new frame discards the old one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 5'd0;
            r_rx      <= 16'h0000;
        end else if (w_cs_fall) begin
            r_bit_cnt <= 5'd0;
            r_rx      <= 16'h0000;
        end else if (w_sclk_rise && w_cs_active) begin
            r_rx      <= w_rx_next;
            r_bit_cnt <= (r_bit_cnt == 5'd31) ? 5'd31 : r_bit_cnt + 5'd1;
        end
    end

    // Transmit shifter: loaded on rise 8, shifted on falls while count is 9..15
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= 8'h00;
        end else if (w_cs_fall || w_cs_rise) begin
            r_tx <= 8'h00;
        end else if (w_load_tx) begin
            r_tx <= w_hdr_write ? 8'h00 : w_rd_data;
        end else if (w_shift_tx) begin
            r_tx <= {r_tx[6:0], 1'b0};
        end
    end

    // Register bank write and write-report outputs at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_rx[14:8];
                r_wr_data <= r_rx[7:0];
                for (int i = 0; i < NREG; i++) begin
                    if (r_rx[14:8] == 7'(i)) begin
                        r_regs[i] <= r_rx[7:0];
                    end
                end
            end
        end
    end

    // One-cycle error pulse when a frame closes with a bit count other than 0 or 16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad_len;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_regs_out
            assign regs[g*8 +: 8] = r_regs[g];
        end
    endgenerate

    assign dout      = r_tx[7];
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed frames plus random frames checked against
// a register-array model of the bank, driven at spi_clk = clk/8.
module tb_spi_reg_slave;

    localparam int NREG = 4;

    logic            clk;
    logic            rst_n;
    logic            spi_clk;
    logic            spi_cs;
    logic            spi_mosi;
    logic            dout;
    logic [7:0]      status;
    logic [NREG*8-1:0] regs;
    logic            wr_strobe;
    logic [6:0]      wr_addr;
    logic [7:0]      wr_data;
    logic            frame_err;

    int checks_r;
    int failures_r;
    int strobe_cnt_r;
    int err_cnt_r;
    logic prev_strobe_r;
    logic [7:0] m_regs [NREG];

    spi_reg_slave #(.NREG(NREG), .STATUS_ADDR(7'h7F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .dout      (dout),
        .status    (status),
        .regs      (regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters for the one-cycle outputs; a strobe must never last two cycles
    always @(posedge clk) begin
        if (wr_strobe) begin
            strobe_cnt_r <= strobe_cnt_r + 1;
            chk("strobe_width", {31'd0, prev_strobe_r}, 32'd0);
        end
        if (frame_err) begin
            err_cnt_r <= err_cnt_r + 1;
        end
        prev_strobe_r <= wr_strobe;
    end

    function automatic logic [31:0] model_flat();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < NREG; i++) v[i*8 +: 8] = m_regs[i];
        return v;
    endfunction

    task automatic cs_start();
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // One spi_clk period; dout is sampled just before the rising edge, as the MCU would
    task automatic send_bit(input logic b, output logic s);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        s = dout;
        spi_clk = 1'b1;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic run_frame(input int nbits, input logic [15:0] word, input string tag);
        int          s0;
        int          e0;
        logic [31:0] samp;
        logic        s;
        logic        w;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [7:0]  exp_rd;
        logic        exp_commit;
        logic        exp_err;
        s0 = strobe_cnt_r;
        e0 = err_cnt_r;
        samp = 32'd0;
        w = word[15];
        a = word[14:8];
        d = word[7:0];
        if (w) exp_rd = 8'h00;
        else if (a < 7'(NREG)) exp_rd = m_regs[a];
        else if (a == 7'h7F) exp_rd = status;
        else exp_rd = 8'h00;
        exp_commit = (nbits == 16) && w && (a < 7'(NREG));
        exp_err = (nbits != 0) && (nbits != 16);
        cs_start();
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < 16) ? word[15 - i] : 1'($urandom_range(0, 1)), s);
            samp = {samp[30:0], s};
        end
        cs_end();
        if (exp_commit) m_regs[a] = d;
        chk({tag, "_strobe"}, 32'(strobe_cnt_r - s0), {31'd0, exp_commit});
        if (exp_commit) begin
            chk({tag, "_wr_addr"}, {25'd0, wr_addr}, {25'd0, a});
            chk({tag, "_wr_data"}, {24'd0, wr_data}, {24'd0, d});
        end
        chk({tag, "_ferr"}, 32'(err_cnt_r - e0), {31'd0, exp_err});
        chk({tag, "_regs"}, regs, model_flat());
        chk({tag, "_dout_idle"}, {31'd0, dout}, 32'd0);
        if (nbits == 16) begin
            chk({tag, "_dout_hdr"}, {24'd0, samp[15:8]}, 32'd0);
            chk({tag, "_dout_data"}, {24'd0, samp[7:0]}, {24'd0, exp_rd});
        end
    endtask

    initial begin
        logic s;
        int   e0;
        int   s0;
        int   nb;
        logic [6:0] ra;
        checks_r = 0;
        failures_r = 0;
        strobe_cnt_r = 0;
        err_cnt_r = 0;
        prev_strobe_r = 1'b0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        rst_n = 1'b0;
        spi_clk = 1'b0;
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        status = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_regs", regs, 32'd0);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(16, 16'h805A, "wr0");
        run_frame(16, 16'h0000, "rd0");
        status = 8'hC3;
        run_frame(16, 16'h7FA5, "rd_status");
        run_frame(16, 16'hFF11, "wr_status");
        run_frame(16, 16'h8577, "wr_oor");
        run_frame(16, 16'h0500, "rd_oor");
        run_frame(12, 16'h82AB, "short12");
        run_frame(20, 16'h82AB, "long20");
        run_frame(0, 16'h0000, "empty");

        // Reset in the middle of a write to addr 1; cs stays low across release
        s0 = strobe_cnt_r;
        e0 = err_cnt_r;
        cs_start();
        for (int i = 0; i < 10; i++) send_bit(1'(16'h81AA >> (15 - i)), s);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        cs_end();
        chk("midrst_regs", regs, 32'd0);
        chk("midrst_strobe", 32'(strobe_cnt_r - s0), 32'd0);
        chk("midrst_ferr", 32'(err_cnt_r - e0), 32'd0);
        run_frame(16, 16'h813C, "wr1");

        // Random frames: mostly full-length, addresses biased to the interesting ones
        for (int k = 0; k < 40; k++) begin
            status = 8'($urandom);
            case ($urandom_range(0, 3))
                0: ra = 7'h7F;
                1: ra = 7'($urandom);
                default: ra = 7'($urandom_range(0, NREG));
            endcase
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            run_frame(nb, {1'($urandom_range(0, 1)), ra, 8'($urandom)}, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- Oversampled SPI slave register bank. The MCU is the SPI initiator; this block is the responder behind the register-bank chip select.
- Produces the `dout` bit that mux_spi forwards to MISO when cs2 is inactive.
- Holds the control registers, including the reg_spi_mux device-select vector that drives mux_spi.
- SPI pins are sampled in the single system clock domain. No logic is clocked by spi_clk.

Parameters:
NREG, 4, number of 8-bit read/write registers, at addresses 0..NREG-1 (NREG ≤ 127).
STATUS_ADDR, 7'h7F, read-only address that returns the `status` input.

Ports:
clk  input  1  system clock; must be ≥ 8× spi_clk frequency
rst_n  input  1  asynchronous active-low reset
spi_clk  input  1  SPI clock from MCU, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
spi_cs  input  1  register-bank chip select, active low
spi_mosi  input  1  MCU data out
dout  output  1  slave data out, to mux_spi `dout`
status  input  8  read-only status byte
regs  output  NREG*8  register contents flat; reg n = regs[8n+7:8n]; reg 0 is reg_spi_mux
wr_strobe  output  1  one-clk pulse when a register write commits
wr_addr  output  7  address of last committed write
wr_data  output  8  data of last committed write
frame_err  output  1  one-clk pulse when a frame ends with a bad bit count

Behaviour:
- Reset (rst_n low, asynchronous):
  - regs = 0, dout = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, frame_err = 0.
  - Bit counter = 0; shift registers = 0.
  - Synchroniser flops reset to idle: cs = 1, clk = 0, mosi = 0.
- Synchronisation and edge detect:
  - spi_clk, spi_cs and spi_mosi each pass through a 2-flop synchroniser.
  - A third flop on clk and cs provides edge detection.
  - An edge is acted on 3 clk cycles after the pin changes.
- Frame format: 16 bits, MSB first.
  - Bit 15 = W (1 = write, 0 = read); bits 14:8 = addr[6:0]; bits 7:0 = data.
- Frame start (cs falling):
  - bit_count = 0, rx shift = 0, dout = 0.
  - Any frame still open is discarded.
- Rising-edge handling (sync clk rising while cs low):
  - Shift sync mosi into the rx shift register.
  - bit_count increments, saturating at 31 (5-bit counter).
- Read data load (on the rising edge that makes bit_count = 8):
  - If W = 0, load the tx shift register with the read data:
    - reg[addr] if addr < NREG;
    - status sampled that cycle if addr = STATUS_ADDR;
    - 0x00 otherwise.
  - If W = 1, the tx shift register is loaded with 0.
  - dout = tx[7] immediately after the load.
- Falling-edge handling (sync clk falling while cs low):
  - Shift tx left by one, 0 in, only when bit_count is in 9..15.
  - The falling edge after rise 8 does not shift, so tx[7] is held until rise 9.
  - dout always equals tx[7].
  - dout changes 3 clk cycles after the spi_clk falling edge. At 8× oversampling this is at least 1 clk before the next rising edge.
- During the address byte and whenever cs is high: dout = 0.
- Frame end (cs rising):
  - If bit_count = 16 and W = 1 and addr < NREG: write reg[addr] = data. On the same cycle drive wr_strobe = 1 and update wr_addr/wr_data; wr_strobe returns to 0 next cycle.
  - If bit_count = 16 and W = 1 and addr ≥ NREG (including STATUS_ADDR): no write and no strobe. Not an error.
  - If bit_count = 16 and W = 0: no side effects.
  - If bit_count is 1..15 or ≥ 17: no write; frame_err pulses for 1 clk.
  - If bit_count = 0 (cs toggled with no clocks): no action.
  - On any frame end, dout returns to 0 and tx is cleared.
- spi_clk edges while sync cs is high are ignored.
- If cs goes high and low within one synchroniser window, it is not guaranteed to be seen. The MCU must hold cs high ≥ 4 clk between frames.
- Reset asserted mid-frame: the frame is abandoned with no write and no frame_err.
  - If spi_cs is already low at reset release, that is seen as a frame start.
  - That frame commits only if exactly 16 rising edges follow.
- regs are registered outputs. A new value is visible on the clk cycle after the commit cycle and is stable otherwise.

Test Plan:
- Write frame 0x80,0x5A (write addr 0) at spi_clk = clk/8 -> wr_strobe single pulse, wr_addr = 0, wr_data = 0x5A, regs[7:0] = 0x5A, frame_err = 0.
- After the above, read frame 0x00,0x00 -> dout = 0 for bits 15:8, then 0,1,0,1,1,0,1,0 sampled on rises 9..16; dout = 0 after cs rises.
- status = 0xC3, read frame 0x7F,xx -> 0xC3 returned MSB first. A write frame 0xFF,0x11 then gives no wr_strobe and regs unchanged.
- Write 0x85,0x77 (addr 5 ≥ NREG) -> no strobe, regs unchanged; a read of addr 5 returns 0x00.
- 12-bit frame then cs high -> frame_err pulse, no write. Repeat with a 20-bit frame -> same result. A cs low/high with no clocks -> no frame_err.
- rst_n low for 2 clk after bit 10 of a write to addr 1 -> regs all 0 and no strobe. The next full write 0x81,0x3C -> regs[15:8] = 0x3C.
